// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the three-port SDRAM request arbiter.
// The optional round-robin mode is enabled by defining SDRAM_ARB_RR_EN.
package sdram_arb_pkg;

  localparam int NPORT   = 3;
  localparam int CALL_WR = 1;
  localparam int CALL_RD = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALL = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

endpackage : sdram_arb_pkg

// File: rtl/sdram_arb_pick.sv
// Combinational winner selection among the three request lines.
// Search order begins at (ptr_i + 1) mod 3.
// A constant pointer of 2 therefore gives fixed priority 0 > 1 > 2.
// The same picker serves both modes selected by SDRAM_ARB_RR_EN.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [NPORT-1:0] req_i,
  input  logic [1:0]       ptr_i,
  output logic [NPORT-1:0] grant_o,
  output logic [1:0]       idx_o,
  output logic             any_o
);

  logic [1:0] first_s;
  logic [1:0] second_s;
  logic [1:0] third_s;

  // Rotate the search order so the port after the pointer is tried first
  always_comb begin
    case (ptr_i)
      2'd0: begin
        first_s  = 2'd1;
        second_s = 2'd2;
        third_s  = 2'd0;
      end
      2'd1: begin
        first_s  = 2'd2;
        second_s = 2'd0;
        third_s  = 2'd1;
      end
      default: begin
        first_s  = 2'd0;
        second_s = 2'd1;
        third_s  = 2'd2;
      end
    endcase
  end

  // Priority chain over the rotated order; one-hot grant plus index
  always_comb begin
    grant_o = 3'b000;
    idx_o   = 2'd0;
    any_o   = 1'b0;
    if (req_i[first_s]) begin
      grant_o = 3'b001 << first_s;
      idx_o   = first_s;
      any_o   = 1'b1;
    end else if (req_i[second_s]) begin
      grant_o = 3'b001 << second_s;
      idx_o   = second_s;
      any_o   = 1'b1;
    end else if (req_i[third_s]) begin
      grant_o = 3'b001 << third_s;
      idx_o   = third_s;
      any_o   = 1'b1;
    end else begin
      grant_o = 3'b000;
      idx_o   = 2'd0;
      any_o   = 1'b0;
    end
  end

endmodule : sdram_arb_pick

// File: rtl/sdram_arbmod.sv
// Three-port arbiter in front of the SDRAM controller call interface.
// It latches the winning client's request and issues one controller call.
// It waits for the matching done pulse, then returns done plus read data.
// Define SDRAM_ARB_RR_EN for round-robin; otherwise fixed priority 0 > 1 > 2.
module sdram_arbmod
  import sdram_arb_pkg::*;
#(
  parameter int AW = 22,
  parameter int DW = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [2:0]        iReq,
  input  logic [2:0]        iWr,
  input  logic [3*AW-1:0]   iAddr,
  input  logic [3*DW-1:0]   iWrData,
  output logic [2:0]        oGrant,
  output logic [2:0]        oDone,
  output logic [DW-1:0]     oRdData,
  output logic [1:0]        oCall,
  output logic [AW-1:0]     oAddr,
  output logic [DW-1:0]     oWrData,
  input  logic [1:0]        iDone,
  input  logic [DW-1:0]     iRdData
);

  arb_state_t state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic [2:0]    done_q, done_d;
  logic [1:0]    call_q, call_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wrdata_q, wrdata_d;
  logic [DW-1:0] rddata_q, rddata_d;
  logic          wr_q, wr_d;

  logic [1:0]    ptr_s;
  logic [2:0]    pick_grant_s;
  logic [1:0]    pick_idx_s;
  logic          pick_any_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wrdata_s;
  logic          sel_wr_s;
  logic          done_match_s;

  sdram_arb_pick u_pick (
    .req_i   (iReq),
    .ptr_i   (ptr_s),
    .grant_o (pick_grant_s),
    .idx_o   (pick_idx_s),
    .any_o   (pick_any_s)
  );

`ifdef SDRAM_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;

  // Pointer follows the winner of every grant
  always_comb begin
    ptr_d = ptr_q;
    if ((state_q == ST_IDLE) && pick_any_s) begin
      ptr_d = pick_idx_s;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; reset to port 2 so port 0 is searched first
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      ptr_q <= 2'd2;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_s = ptr_q;
`else
  assign ptr_s = 2'd2;
`endif

  // Route the winning client's address, data and direction
  always_comb begin
    case (pick_idx_s)
      2'd0: begin
        sel_addr_s   = iAddr[0*AW +: AW];
        sel_wrdata_s = iWrData[0*DW +: DW];
        sel_wr_s     = iWr[0];
      end
      2'd1: begin
        sel_addr_s   = iAddr[1*AW +: AW];
        sel_wrdata_s = iWrData[1*DW +: DW];
        sel_wr_s     = iWr[1];
      end
      default: begin
        sel_addr_s   = iAddr[2*AW +: AW];
        sel_wrdata_s = iWrData[2*DW +: DW];
        sel_wr_s     = iWr[2];
      end
    endcase
  end

  // Only the done bit matching the issued direction completes a call
  assign done_match_s = wr_q ? iDone[CALL_WR] : iDone[CALL_RD];

  // Next-state and next-output logic for the transaction sequence
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = 3'b000;
    call_d   = call_q;
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    rddata_d = rddata_q;
    wr_d     = wr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          grant_d  = pick_grant_s;
          addr_d   = sel_addr_s;
          wrdata_d = sel_wrdata_s;
          wr_d     = sel_wr_s;
          call_d   = sel_wr_s ? 2'b10 : 2'b01;
          state_d  = ST_CALL;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_CALL: begin
        if (done_match_s) begin
          call_d  = 2'b00;
          done_d  = grant_q;
          state_d = ST_RESP;
          if (!wr_q) begin
            rddata_d = iRdData;
          end else begin
            rddata_d = rddata_q;
          end
        end else begin
          state_d = ST_CALL;
        end
      end
      ST_RESP: begin
        state_d = ST_GAP;
      end
      ST_GAP: begin
        grant_d = 3'b000;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = 3'b000;
        call_d  = 2'b00;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      grant_q  <= 3'b000;
      done_q   <= 3'b000;
      call_q   <= 2'b00;
      addr_q   <= '0;
      wrdata_q <= '0;
      rddata_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      call_q   <= call_d;
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      rddata_q <= rddata_d;
      wr_q     <= wr_d;
    end
  end

  assign oGrant  = grant_q;
  assign oDone   = done_q;
  assign oCall   = call_q;
  assign oAddr   = addr_q;
  assign oWrData = wrdata_q;
  assign oRdData = rddata_q;

endmodule : sdram_arbmod

// File: tb/tb_sdram_arbmod.sv
// Self-checking bench for sdram_arbmod; the bench plays all clients and the controller.
module tb_sdram_arbmod;

  localparam int AW = 22;
  localparam int DW = 16;

  logic            CLOCK = 1'b0;
  logic            RESET;
  logic [2:0]      iReq;
  logic [2:0]      iWr;
  logic [3*AW-1:0] iAddr;
  logic [3*DW-1:0] iWrData;
  logic [2:0]      oGrant;
  logic [2:0]      oDone;
  logic [DW-1:0]   oRdData;
  logic [1:0]      oCall;
  logic [AW-1:0]   oAddr;
  logic [DW-1:0]   oWrData;
  logic [1:0]      iDone;
  logic [DW-1:0]   iRdData;

  int checks   = 0;
  int failures = 0;

  // Reference state: last granted port and last completed read value
  int            last_w = 2;
  logic [DW-1:0] exp_rd = '0;

  sdram_arbmod #(.AW(AW), .DW(DW)) dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .iReq    (iReq),
    .iWr     (iWr),
    .iAddr   (iAddr),
    .iWrData (iWrData),
    .oGrant  (oGrant),
    .oDone   (oDone),
    .oRdData (oRdData),
    .oCall   (oCall),
    .oAddr   (oAddr),
    .oWrData (oWrData),
    .iDone   (iDone),
    .iRdData (iRdData)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Winner according to the arbitration rule, from the request vector alone
  function automatic int model_pick(input logic [2:0] req);
    int p;
`ifdef SDRAM_ARB_RR_EN
    for (int k = 1; k <= 3; k++) begin
      p = (last_w + k) % 3;
      if (req[p]) return p;
    end
`else
    for (int k = 0; k < 3; k++) begin
      p = k;
      if (req[p]) return p;
    end
`endif
    return -1;
  endfunction

  // One complete transaction from the IDLE state back to IDLE
  task automatic serve(input int lat, input logic [DW-1:0] rd, input bit spur,
                       input bit both, input bit scramble, input bit keep,
                       output logic [2:0] g_obs);
    int            w;
    logic          dir;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0]    ec;
    logic [2:0]    req_saved;
    req_saved = iReq;
    w   = model_pick(iReq);
    dir = iWr[w];
    a   = iAddr[w*AW +: AW];
    d   = iWrData[w*DW +: DW];
    ec  = dir ? 2'b10 : 2'b01;
    tick();
    g_obs = oGrant;
    chk("grant", 32'(oGrant), 32'(1 << w));
    chk("call_start", 32'(oCall), 32'(ec));
    chk("addr", 32'(oAddr), 32'(a));
    chk("wrdata", 32'(oWrData), 32'(d));
    chk("done_at_grant", 32'(oDone), 32'(0));
    last_w = w;
    if (scramble) begin
      iReq  = ~iReq;
      iWr   = ~iWr;
      iAddr = ~iAddr;
    end
    for (int i = 0; i < lat - 1; i++) begin
      iDone = (spur && i == 0) ? ~ec : 2'b00;
      iRdData = 16'($urandom);
      tick();
      chk("call_hold", 32'(oCall), 32'(ec));
      chk("done_hold", 32'(oDone), 32'(0));
      chk("addr_hold", 32'(oAddr), 32'(a));
    end
    iDone   = both ? 2'b11 : ec;
    iRdData = rd;
    tick();
    iDone   = 2'b00;
    iRdData = 16'($urandom);
    if (!dir) exp_rd = rd;
    chk("call_clear", 32'(oCall), 32'(0));
    chk("done_pulse", 32'(oDone), 32'(1 << w));
    chk("rddata", 32'(oRdData), 32'(exp_rd));
    iReq = keep ? req_saved : 3'b000;
    if (scramble) begin
      iWr   = ~iWr;
      iAddr = ~iAddr;
    end
    tick();
    chk("done_once", 32'(oDone), 32'(0));
    chk("gap_grant", 32'(oGrant), 32'(1 << w));
    chk("gap_call", 32'(oCall), 32'(0));
    tick();
    chk("idle_grant", 32'(oGrant), 32'(0));
    chk("idle_call", 32'(oCall), 32'(0));
    chk("rd_hold", 32'(oRdData), 32'(exp_rd));
  endtask

  initial begin
    logic [2:0] g;
    int         order_exp [6];
    int         lat;
    bit         spur;

    RESET   = 1'b1;
    iReq    = 3'b000;
    iWr     = 3'b000;
    iAddr   = '0;
    iWrData = '0;
    iDone   = 2'b00;
    iRdData = '0;
    tick();
    tick();
    chk("rst_grant", 32'(oGrant), 32'(0));
    chk("rst_done", 32'(oDone), 32'(0));
    chk("rst_call", 32'(oCall), 32'(0));
    chk("rst_addr", 32'(oAddr), 32'(0));
    chk("rst_wrdata", 32'(oWrData), 32'(0));
    chk("rst_rddata", 32'(oRdData), 32'(0));
    RESET = 1'b0;
    tick();

    // Single read on port 1, controller answers 0xBEEF after 5 cycles
    iReq = 3'b010;
    iWr  = 3'b000;
    iAddr[1*AW +: AW] = 22'h00123;
    serve(5, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0, g);
    chk("rd_port1_beef", 32'(oRdData), 32'hBEEF);

    // Single write on port 2; read data must stay 0xBEEF
    iReq = 3'b100;
    iWr  = 3'b100;
    iWrData[2*DW +: DW] = 16'h5A5A;
    serve(3, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, g);
    chk("wr_keeps_rd", 32'(oRdData), 32'hBEEF);

    // All three ports requesting continuously
`ifdef SDRAM_ARB_RR_EN
    order_exp = '{0, 1, 2, 0, 1, 2};
`else
    order_exp = '{0, 0, 0, 0, 0, 0};
`endif
    iReq = 3'b111;
    iWr  = 3'b000;
    for (int i = 0; i < 6; i++) begin
      serve(2, 16'(16'h0100 + i), 1'b0, 1'b0, 1'b0, 1'b1, g);
      chk("order", 32'(g), 32'(1 << order_exp[i]));
    end
    iReq = 3'b000;
    tick();
    chk("order_drain", 32'(oGrant), 32'(0));

    // Spurious write-done during a read is ignored
    iReq = 3'b001;
    iWr  = 3'b000;
    serve(4, 16'h7777, 1'b1, 1'b0, 1'b0, 1'b0, g);

    // Spurious read-done while idle gives no done
    iDone = 2'b01;
    tick();
    iDone = 2'b00;
    chk("idle_spur_done", 32'(oDone), 32'(0));
    chk("idle_spur_grant", 32'(oGrant), 32'(0));
    tick();
    chk("idle_spur_done2", 32'(oDone), 32'(0));

    // Reset while a call is outstanding, then a late controller done
    iReq = 3'b001;
    iWr  = 3'b000;
    iAddr[0*AW +: AW] = 22'h3ABCD;
    tick();
    chk("pre_rst_call", 32'(oCall), 32'(2'b01));
    RESET = 1'b1;
    iReq  = 3'b000;
    tick();
    RESET = 1'b0;
    chk("mid_rst_call", 32'(oCall), 32'(0));
    chk("mid_rst_grant", 32'(oGrant), 32'(0));
    chk("mid_rst_addr", 32'(oAddr), 32'(0));
    chk("mid_rst_rd", 32'(oRdData), 32'(0));
    last_w = 2;
    exp_rd = '0;
    iDone = 2'b01;
    iRdData = 16'hDEAD;
    tick();
    iDone = 2'b00;
    chk("late_done", 32'(oDone), 32'(0));
    tick();
    chk("late_done2", 32'(oDone), 32'(0));
    chk("late_call", 32'(oCall), 32'(0));

    // Randomised traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      iReq    = 3'($urandom_range(1, 7));
      iWr     = 3'($urandom);
      iAddr   = 66'({$urandom(), $urandom(), $urandom()});
      iWrData = 48'({$urandom(), $urandom()});
      lat     = $urandom_range(1, 6);
      spur    = (lat > 1) && ($urandom_range(0, 1) == 1);
      serve(lat, 16'($urandom), spur, 1'($urandom), 1'($urandom), 1'b0, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sdram_arbmod
